// File: rtl/load_align_unit.sv
// load_align_unit
//   Load-data unit sitting between the memory stage and a 1-cycle synchronous
//   data RAM. A byte-addressed load becomes one or two word reads. The bytes
//   are merged, then sign- or zero-extended to XLEN, and the result is sent to
//   writeback as a single-cycle pulse.
//
//   Parameters
//     XLEN    data / word width, 32 or 64 (LANES = XLEN/8 byte lanes)
//     ADDR_W  byte address width
//
//   Ports
//     clk, rst_n        clock, synchronous active-low reset
//     flush             abort the in-flight load (no response is produced)
//     req_valid/ready   load request handshake
//     req_addr          byte address
//     req_type          RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU)
//     mem_rd_en         data RAM read strobe (registered)
//     mem_addr          data RAM word address (registered)
//     mem_rd_data       RAM read data, valid the cycle after mem_rd_en
//     resp_valid        one-cycle result pulse
//     resp_data         extended load result, held until the next response
//     resp_err          illegal type, or an unsupported word-crossing access
//     resp_split        the access needed two reads
//
//   Build option
//     MISALIGN_SPLIT_EN  when defined, word-crossing loads are serviced with
//                        two reads. When undefined, they are answered with
//                        resp_err, and resp_split is tied low.

// One output byte lane: pass the aligned byte through if it lies inside the
// access size, otherwise drive the extension fill.
module lau_lane #(
    parameter int LANE = 0
) (
    input  logic [7:0] byte_in,
    input  logic [1:0] szc,
    input  logic [7:0] fill,
    output logic [7:0] byte_out
);
    logic [3:0] nbytes;

    assign nbytes   = 4'd1 << szc;
    assign byte_out = (4'(LANE) < nbytes) ? byte_in : fill;
endmodule

module load_align_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [ADDR_W-1:0]                    req_addr,
    input  logic [2:0]                           req_type,
    output logic                                 mem_rd_en,
    output logic [ADDR_W-$clog2(XLEN/8)-1:0]     mem_addr,
    input  logic [XLEN-1:0]                      mem_rd_data,
    output logic                                 resp_valid,
    output logic [XLEN-1:0]                      resp_data,
    output logic                                 resp_err,
    output logic                                 resp_split
);
    localparam int LANES = XLEN / 8;
    localparam int OFFW  = $clog2(LANES);
    localparam int WA_W  = ADDR_W - OFFW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE0 = 2'd1,
        ISSUE1 = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            state;
    logic [WA_W-1:0]   w0_q;
    logic [OFFW-1:0]   off_q;
    logic [1:0]        szc_q;    // log2 of access size in bytes
    logic              uns_q;    // zero-extend (LBU/LHU/LWU)
    logic              err_q;

    // ---------------- request decode ----------------
    logic [1:0]        req_szc;
    logic [OFFW-1:0]   req_off;
    logic [4:0]        req_end;
    logic              req_ill;
    logic              req_cross;
    logic              req_bad;

    assign req_szc   = req_type[1:0];
    assign req_off   = req_addr[OFFW-1:0];
    assign req_end   = 5'(req_off) + (5'd1 << req_szc);
    assign req_cross = req_end > 5'(LANES);
    assign req_ill   = (req_type == 3'b111) ||
                       ((XLEN == 32) && ((req_type == 3'b011) || (req_type == 3'b110)));

`ifdef MISALIGN_SPLIT_EN
    logic              cross_q;
    logic [XLEN-1:0]   lo_q;     // first word of a crossing access
    assign req_bad = req_ill;
`else
    assign req_bad = req_ill || req_cross;
    assign resp_split = 1'b0;
`endif

    assign req_ready = (state == IDLE) && !flush;

    // ---------------- merge / extend ----------------
    // The last word arrives on mem_rd_data during FINISH. For a crossing access
    // it is the high half of the window, and the low half was captured in ISSUE1.
    logic [2*XLEN-1:0]             cat;
    logic [XLEN-1:0]               shifted;
    logic [3:0]                    nbytes;
    logic                          sign;
    logic [LANES-1:0][7:0]         merged;

`ifdef MISALIGN_SPLIT_EN
    assign cat = cross_q ? {mem_rd_data, lo_q} : {{XLEN{1'b0}}, mem_rd_data};
`else
    assign cat = {{XLEN{1'b0}}, mem_rd_data};
`endif

    assign shifted = XLEN'(cat >> {off_q, 3'b000});
    assign nbytes  = 4'd1 << szc_q;

    // Sign bit is the MSB of the top byte inside the access.
    always_comb begin
        sign = 1'b0;
        for (int k = 0; k < LANES; k++)
            if (nbytes == 4'(k + 1)) sign = shifted[8*k+7];
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lau_lane #(.LANE(i)) u_lane (
            .byte_in  (shifted[8*i +: 8]),
            .szc      (szc_q),
            .fill     ({8{sign & ~uns_q}}),
            .byte_out (merged[i])
        );
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            w0_q       <= '0;
            off_q      <= '0;
            szc_q      <= '0;
            uns_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            resp_split <= 1'b0;
            cross_q    <= 1'b0;
            lo_q       <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            if (flush) begin
                // Abort: any read data still in flight is simply never used.
                state     <= IDLE;
                mem_rd_en <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid) begin
                            w0_q  <= req_addr[ADDR_W-1:OFFW];
                            off_q <= req_off;
                            szc_q <= req_szc;
                            uns_q <= req_type[2];
                            err_q <= req_bad;
`ifdef MISALIGN_SPLIT_EN
                            cross_q <= req_cross;
`endif
                            if (req_bad) begin
                                state <= FINISH;
                            end else begin
                                state     <= ISSUE0;
                                mem_rd_en <= 1'b1;
                                mem_addr  <= req_addr[ADDR_W-1:OFFW];
                            end
                        end
                    end
                    ISSUE0: begin
`ifdef MISALIGN_SPLIT_EN
                        if (cross_q) begin
                            // Wraps at the top of the address space.
                            state    <= ISSUE1;
                            mem_addr <= w0_q + WA_W'(1);
                        end else begin
                            state     <= FINISH;
                            mem_rd_en <= 1'b0;
                        end
`else
                        state     <= FINISH;
                        mem_rd_en <= 1'b0;
`endif
                    end
`ifdef MISALIGN_SPLIT_EN
                    ISSUE1: begin
                        lo_q      <= mem_rd_data;
                        mem_rd_en <= 1'b0;
                        state     <= FINISH;
                    end
`endif
                    FINISH: begin
                        resp_valid <= 1'b1;
                        resp_err   <= err_q;
                        resp_data  <= err_q ? '0 : merged;
`ifdef MISALIGN_SPLIT_EN
                        resp_split <= cross_q && !err_q;
`endif
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_load_align_unit.sv
module tb_load_align_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, req_valid, sel64;
    logic [31:0] req_addr;
    logic [2:0]  req_type;

    logic        rdy32, en32, rv32, err32, spl32;
    logic [29:0] ma32;
    logic [31:0] rd32 = '0;
    logic [31:0] d32;
    logic        rdy64, en64, rv64, err64, spl64;
    logic [28:0] ma64;
    logic [63:0] rd64 = '0;
    logic [63:0] d64;

    load_align_unit #(.XLEN(32), .ADDR_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid & ~sel64), .req_ready(rdy32),
        .req_addr(req_addr), .req_type(req_type),
        .mem_rd_en(en32), .mem_addr(ma32), .mem_rd_data(rd32),
        .resp_valid(rv32), .resp_data(d32), .resp_err(err32), .resp_split(spl32)
    );

    load_align_unit #(.XLEN(64), .ADDR_W(32)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid & sel64), .req_ready(rdy64),
        .req_addr(req_addr), .req_type(req_type),
        .mem_rd_en(en64), .mem_addr(ma64), .mem_rd_data(rd64),
        .resp_valid(rv64), .resp_data(d64), .resp_err(err64), .resp_split(spl64)
    );

    // 1-cycle synchronous RAMs
    logic [31:0] m32 [logic [29:0]];
    logic [63:0] m64 [logic [28:0]];
    always @(posedge clk) if (en32) rd32 <= m32.exists(ma32) ? m32[ma32] : 32'h0;
    always @(posedge clk) if (en64) rd64 <= m64.exists(ma64) ? m64[ma64] : 64'h0;

    // View of whichever DUT is selected
    logic        rdy, en, rv, err, spl;
    logic [29:0] madr;
    logic [63:0] data;
    assign rdy  = sel64 ? rdy64 : rdy32;
    assign en   = sel64 ? en64  : en32;
    assign rv   = sel64 ? rv64  : rv32;
    assign err  = sel64 ? err64 : err32;
    assign spl  = sel64 ? spl64 : spl32;
    assign madr = sel64 ? {1'b0, ma64} : ma32;
    assign data = sel64 ? d64 : {32'h0, d32};

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request (caller is at a negedge) and follow it to its response.
    // Returns at the negedge of the resp_valid cycle, so back-to-back calls
    // issue the next request in the response cycle.
    task automatic run(input string tag, input bit w64, input logic [31:0] addr,
                       input logic [2:0] typ, input int exp_lat, input logic [63:0] exp_d,
                       input logic exp_err, input logic exp_spl, input int exp_reads,
                       input logic [29:0] a0, input logic [29:0] a1);
        int lat, nrd;
        logic [29:0] ad [2];
        sel64 = w64; req_addr = addr; req_type = typ; req_valid = 1'b1;
        #1 chk({tag, ".ready"}, 64'(rdy), 64'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 0; nrd = 0; ad[0] = '0; ad[1] = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (en) begin
                if (nrd < 2) ad[nrd] = madr;
                nrd++;
            end
            if (rv) begin
                lat = n;
                break;
            end
        end
        chk({tag, ".lat"},   64'(lat), 64'(exp_lat));
        chk({tag, ".data"},  data, exp_d);
        chk({tag, ".err"},   64'(err), 64'(exp_err));
        chk({tag, ".split"}, 64'(spl), 64'(exp_spl));
        chk({tag, ".reads"}, 64'(nrd), 64'(exp_reads));
        if (exp_reads >= 1) chk({tag, ".addr0"}, 64'(ad[0]), 64'(a0));
        if (exp_reads >= 2) chk({tag, ".addr1"}, 64'(ad[1]), 64'(a1));
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; sel64 = 1'b0;
        req_addr = '0; req_type = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.valid", 64'(rv), 64'd0);
        chk("rst.err",   64'(err), 64'd0);
        chk("rst.split", 64'(spl), 64'd0);
        chk("rst.rden",  64'(en), 64'd0);
        chk("rst.data",  data, 64'd0);
        chk("rst.maddr", 64'(madr), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- XLEN=32 ----
        m32[30'h400] = 32'h80FF1234;
        run("lb", 0, 32'h1003, 3'b000, 3, 64'hFFFFFF80, 0, 0, 1, 30'h400, 0);
        @(negedge clk);
        chk("hold.valid", 64'(rv), 64'd0);
        chk("hold.data",  data, 64'hFFFFFF80);

        m32[30'h400] = 32'hBEEF0000;
        run("lhu",    0, 32'h1002, 3'b101, 3, 64'h0000BEEF, 0, 0, 1, 30'h400, 0);
        run("lw_b2b", 0, 32'h1000, 3'b010, 3, 64'hBEEF0000, 0, 0, 1, 30'h400, 0);

        m32[30'h400] = 32'h44332211;
        m32[30'h401] = 32'h88776655;
        m32[30'h3FFFFFFF] = 32'h80000000;
        m32[30'h0] = 32'h000000FF;
`ifdef MISALIGN_SPLIT_EN
        run("lw_cross", 0, 32'h1001, 3'b010, 4, 64'h55443322, 0, 1, 2, 30'h400, 30'h401);
        run("lh_wrap",  0, 32'hFFFFFFFF, 3'b001, 4, 64'hFFFFFF80, 0, 1, 2, 30'h3FFFFFFF, 30'h0);
`else
        run("lw_cross", 0, 32'h1001, 3'b010, 2, 64'h0, 1, 0, 0, 0, 0);
        run("lh_wrap",  0, 32'hFFFFFFFF, 3'b001, 2, 64'h0, 1, 0, 0, 0, 0);
`endif
        run("ld32",  0, 32'h1000, 3'b011, 2, 64'h0, 1, 0, 0, 0, 0);
        run("lwu32", 0, 32'h1000, 3'b110, 2, 64'h0, 1, 0, 0, 0, 0);
        run("ill32", 0, 32'h1000, 3'b111, 2, 64'h0, 1, 0, 0, 0, 0);

        // ---- XLEN=64 ----
        m64[29'h0] = 64'h8123456789ABCDEF;
        run("ld64", 1, 32'h0, 3'b011, 3, 64'h8123456789ABCDEF, 0, 0, 1, 0, 0);
        run("lb64", 1, 32'h7, 3'b000, 3, 64'hFFFFFFFFFFFFFF81, 0, 0, 1, 0, 0);
        m64[29'h0] = 64'hFFFFFFFF00000000;
        m64[29'h1] = 64'h0000000000001234;
        run("lwu64", 1, 32'h4, 3'b110, 3, 64'h00000000FFFFFFFF, 0, 0, 1, 0, 0);
        run("lw64",  1, 32'h4, 3'b010, 3, 64'hFFFFFFFFFFFFFFFF, 0, 0, 1, 0, 0);
        run("ill64", 1, 32'h4, 3'b111, 2, 64'h0, 1, 0, 0, 0, 0);
`ifdef MISALIGN_SPLIT_EN
        run("lw64_cross", 1, 32'h6, 3'b010, 4, 64'h000000001234FFFF, 0, 1, 2, 30'h0, 30'h1);
`else
        run("lw64_cross", 1, 32'h6, 3'b010, 2, 64'h0, 1, 0, 0, 0, 0);
`endif

        // ---- flush of an in-flight load (ISSUE1 when splitting, else FINISH) ----
        sel64 = 1'b0; req_type = 3'b010; req_valid = 1'b1;
`ifdef MISALIGN_SPLIT_EN
        req_addr = 32'h1001;
`else
        req_addr = 32'h1000;
`endif
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush.ready", 64'(rdy), 64'd1);
        seen = rv ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (rv) seen = 1;
        end
        chk("flush.noresp", 64'(seen), 64'd0);

        // ---- flush together with a request in IDLE ----
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h1000; req_type = 3'b010;
        #1 chk("flushreq.ready", 64'(rdy), 64'd0);
        @(posedge clk); #1 begin flush = 1'b0; req_valid = 1'b0; end
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rv || en) seen = 1;
        end
        chk("flushreq.idle", 64'(seen), 64'd0);

        // ---- reset during ISSUE0 ----
        m32[30'h400] = 32'h80FF1234;
        run("lb_pre", 0, 32'h1003, 3'b000, 3, 64'hFFFFFF80, 0, 0, 1, 30'h400, 0);
        req_addr = 32'h1003; req_type = 3'b000; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid.issue0", 64'(en), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid.valid", 64'(rv), 64'd0);
        chk("rstmid.rden",  64'(en), 64'd0);
        chk("rstmid.data",  data, 64'd0);
        chk("rstmid.err",   64'(err), 64'd0);
        chk("rstmid.maddr", 64'(madr), 64'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rv) seen = 1;
        end
        chk("rstmid.noresp", 64'(seen), 64'd0);
        run("lb_post", 0, 32'h1003, 3'b000, 3, 64'hFFFFFF80, 0, 0, 1, 30'h400, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
